// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
//   state_t    - receiver frame state
//   SAMPLE_MID - centre sample index within a 16-tick bit period
//   BIT_END    - sample index whose tick closes a bit period
//   calc_div   - clocks per oversample tick, rounded to nearest, never below 1
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam int SAMPLE_MID = 8;
  localparam int BIT_END    = 15;

  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int tick_hz;
    int d;
    tick_hz = baud * oversample;
    d = (clk_hz + tick_hz / 2) / tick_hz;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one clk-wide pulse every DIV clocks.
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   restart - clears the divider so the next tick lands DIV clocks later
//   tick    - registered single-cycle pulse
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, 16x oversampling, 3-sample majority per bit,
// false-start rejection and a single-entry valid/ready holding register.
//   clk, rst  - system clock, asynchronous active-high reset
//   rx        - raw asynchronous serial line, idle high
//   rx_data   - received byte, valid while rx_valid
//   rx_valid  - byte available, held until rx_ready accepts it
//   rx_ready  - consumer accepts on rx_valid & rx_ready at posedge
//   frame_err - one-cycle pulse, stop bit sampled low
//   overrun   - one-cycle pulse, byte completed while holding register full
//   busy      - receiver not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam logic [3:0] S_FIRST = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] S_LAST  = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] S_END   = 4'(BIT_END);

  state_t     state, state_d;
  logic       rx_meta, rx_s;
  logic       tick, restart, bit_end, maj;
  logic       byte_done, fe_set;
  logic [3:0] s;
  logic [2:0] bit_idx;
  logic [2:0] samples;
  logic [7:0] shift_reg;

  // Synchroniser flops reset high so reset release never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign bit_end = tick && (s == S_END);
  assign maj     = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    restart   = 1'b0;
    byte_done = 1'b0;
    fe_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          restart = 1'b1;   // phase-align sampling to the falling edge
        end
      end
      START: begin
        if (bit_end) state_d = maj ? IDLE : DATA;   // high majority = glitch
      end
      DATA: begin
        if (bit_end && bit_idx == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (maj) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;   // wait out a break before hunting again
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing and byte assembly. The assembly register is only copied out on
  // byte_done, so an aborted frame never reaches rx_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      bit_idx   <= '0;
      samples   <= '0;
      shift_reg <= '0;
    end else begin
      if (restart) begin
        s <= '0;
      end else if (tick && (state inside {START, DATA, STOP})) begin
        s <= s + 4'd1;
        if (s >= S_FIRST && s <= S_LAST) samples <= {samples[1:0], rx_s};
      end
      if (state == START && bit_end) bit_idx <= '0;
      if (state == DATA && bit_end) begin
        shift_reg[bit_idx] <= maj;   // LSB first
        bit_idx            <= bit_idx + 3'd1;
      end
    end
  end

  // Holding register and status pulses. A byte arriving while full is only
  // accepted if the consumer takes the old byte in that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_set;
      overrun   <= byte_done && rx_valid && !rx_ready;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 64 clk per bit (DIV = 4).
module tb_uart_rx;

  localparam int CLK_HZ   = 6400000;
  localparam int BAUD     = 100000;
  localparam int BIT_CLKS = 64;
  localparam int LAT_MIN  = 641;   // fall-edge drive to rx_valid rise, in clocks
  localparam int LAT_MAX  = 648;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         rd_idx = 0;
  int         last_rise = 0;
  logic [7:0] got_b, exp_b;

  // Monitor: sampled on the falling edge, inputs are driven 2 ns after rising.
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, valid_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (rx_valid) valid_cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drives one 8N1 frame plus 'tail' idle clocks. With tail = 0 the line is
  // left at stop_bit. rx_ready is pulsed high for posedge number ready_step
  // only (if >= 0). rise is the posedge count at which rx_valid went 0->1.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int tail,
                            input int ready_step, output int rise);
    logic prev;
    int   bit_n;
    rise = -1;
    prev = rx_valid;
    for (int n = 0; n < 10 * BIT_CLKS + tail; n++) begin
      bit_n = n / BIT_CLKS;
      if (bit_n == 0)      rx = 1'b0;
      else if (bit_n <= 8) rx = b[3'(bit_n - 1)];
      else if (bit_n == 9) rx = stop_bit;
      else                 rx = 1'b1;
      if (ready_step >= 0) rx_ready = (n + 1 == ready_step);
      step(1);
      if (!prev && rx_valid && rise < 0) rise = n + 1;
      prev = rx_valid;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    n_checks++;
    if ({rx_data, rx_valid, frame_err, overrun} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%02h v=%b fe=%b ov=%b, expected all 0",
               rx_data, rx_valid, frame_err, overrun);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    rst = 1'b0;
    step(4);
  endtask

  task automatic test_basic;
    int fe0, ov0, v0, rise;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = valid_cyc;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 32, -1, rise);
    last_rise = rise;
    n_checks++;
    if (rise < LAT_MIN || rise > LAT_MAX) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d clk, expected %0d..%0d", rise, LAT_MIN, LAT_MAX);
    end
    n_checks++;
    if (valid_cyc - v0 != 1) begin
      n_fail++;
      $display("FAIL basic_valid_width: got %0d cycles, expected 1", valid_cyc - v0);
    end
    n_checks++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin
      n_fail++;
      $display("FAIL basic_flags: got fe=%0d ov=%0d pulses, expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got %b, expected 0", busy);
    end
    while (rd_idx < got_q.size()) begin
      got_b = got_q[rd_idx]; rd_idx++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL basic_extra: got byte %02h, expected none", got_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_b !== exp_b) begin
          n_fail++; $display("FAIL basic_data: got %02h, expected %02h", got_b, exp_b);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_missing: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_false_start;
    int fe0, v0, g0;
    fe0 = fe_cnt; v0 = valid_cyc; g0 = got_q.size();
    rx = 1'b0;
    step(10);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL glitch_start: busy got %b, expected 1", busy);
    end
    step(10);
    rx = 1'b1;
    step(36);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL glitch_hold: busy got %b before bit end, expected 1", busy);
    end
    step(24);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL glitch_abort: busy got %b after bit end, expected 0", busy);
    end
    n_checks++;
    if (valid_cyc != v0 || fe_cnt != fe0 || got_q.size() != g0) begin
      n_fail++;
      $display("FAIL glitch_quiet: got valid=%0d fe=%0d bytes=%0d, expected 0 0 0",
               valid_cyc - v0, fe_cnt - fe0, got_q.size() - g0);
    end
  endtask

  task automatic test_frame_error;
    int fe0, v0, rise;
    fe0 = fe_cnt; v0 = valid_cyc;
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 0, -1, rise);
    step(BIT_CLKS);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL ferr_wait_high: busy got %b on stuck-low line, expected 1", busy);
    end
    rx = 1'b1;
    step(2 * BIT_CLKS);
    n_checks++;
    if (fe_cnt - fe0 != 1) begin
      n_fail++; $display("FAIL ferr_pulse: got %0d cycles, expected 1", fe_cnt - fe0);
    end
    n_checks++;
    if (valid_cyc != v0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_discard: got valid=%0d busy=%b, expected 0 0", valid_cyc - v0, busy);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 32, -1, rise);
    while (rd_idx < got_q.size()) begin
      got_b = got_q[rd_idx]; rd_idx++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL ferr_extra: got byte %02h, expected none", got_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_b !== exp_b) begin
          n_fail++; $display("FAIL ferr_data: got %02h, expected %02h", got_b, exp_b);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || fe_cnt - fe0 != 1) begin
      n_fail++;
      $display("FAIL ferr_recover: got outstanding=%0d fe=%0d, expected 0 1", exp_q.size(), fe_cnt - fe0);
      exp_q.delete();
    end
  endtask

  task automatic test_overrun;
    int ov0, fe0, rise;
    ov0 = ov_cnt; fe0 = fe_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 64, -1, rise);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_fail++; $display("FAIL ovr_first: got v=%b data=%02h, expected 1 11", rx_valid, rx_data);
    end
    send_frame(8'h22, 1'b1, 64, -1, rise);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_fail++; $display("FAIL ovr_retain: got v=%b data=%02h, expected 1 11", rx_valid, rx_data);
    end
    n_checks++;
    if (ov_cnt - ov0 != 1 || fe_cnt - fe0 != 0 || both_cnt != 0) begin
      n_fail++;
      $display("FAIL ovr_pulse: got ov=%0d fe=%0d both=%0d, expected 1 0 0", ov_cnt - ov0, fe_cnt - fe0, both_cnt);
    end
    rx_ready = 1'b1;
    step(1);
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_accept_clear: rx_valid got %b, expected 0", rx_valid);
    end
    while (rd_idx < got_q.size()) begin
      got_b = got_q[rd_idx]; rd_idx++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL ovr_extra: got byte %02h, expected none", got_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_b !== exp_b) begin
          n_fail++; $display("FAIL ovr_data: got %02h, expected %02h", got_b, exp_b);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL ovr_missing: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    int ov0, r1, r2;
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 64, -1, r1);
    n_checks++;
    if (r1 < LAT_MIN || r1 > LAT_MAX || r1 != last_rise) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d clk, expected %0d (range %0d..%0d)", r1, last_rise, LAT_MIN, LAT_MAX);
    end
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 64, r1, r2);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
      n_fail++; $display("FAIL b2b_load: got v=%b data=%02h, expected 1 22", rx_valid, rx_data);
    end
    n_checks++;
    if (ov_cnt != ov0) begin
      n_fail++; $display("FAIL b2b_overrun: got %0d pulses, expected 0", ov_cnt - ov0);
    end
    rx_ready = 1'b1;
    step(2);
    rx_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: rx_valid got %b, expected 0", rx_valid);
    end
    while (rd_idx < got_q.size()) begin
      got_b = got_q[rd_idx]; rd_idx++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_extra: got byte %02h, expected none", got_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_b !== exp_b) begin
          n_fail++; $display("FAIL b2b_data: got %02h, expected %02h", got_b, exp_b);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_missing: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int v0, rise;
    b = 8'h5A;
    rx_ready = 1'b1;
    rx = 1'b0;
    step(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      step(BIT_CLKS);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_frame: busy got %b, expected 1", busy);
    end
    rst = 1'b1;
    step(1);
    n_checks++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got data=%02h v=%b fe=%b ov=%b busy=%b, expected all 0",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
    rx = 1'b1;
    step(4);
    rst = 1'b0;
    v0 = valid_cyc;
    step(2 * BIT_CLKS);
    n_checks++;
    if (valid_cyc != v0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_fragment: got valid=%0d busy=%b, expected 0 0", valid_cyc - v0, busy);
    end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 32, -1, rise);
    while (rd_idx < got_q.size()) begin
      got_b = got_q[rd_idx]; rd_idx++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rstmid_extra: got byte %02h, expected none", got_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_b !== exp_b) begin
          n_fail++; $display("FAIL rstmid_data: got %02h, expected %02h", got_b, exp_b);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_missing: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
